hazard_scoreboard_ctrl: RTL

// - Next-generation hazard unit for the 5-stage RISC-V pipeline: EX-stage forwarding, load-use stall, redirect flush.
// - Adds a NUM_SB-entry scoreboard for variable-latency ops (div, uncached load) that complete out of band at WB.
// - Drives PC/IF-ID write enables and IF-ID/ID-EX flushes; counts stall cycles for perf.

---
 rtl/hazard_scoreboard_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard_ctrl.sv
// hazard_scoreboard_ctrl
// Hazard unit for a 5-stage RISC-V pipeline. It does three jobs:
//   - chooses the EX-stage forwarding source for each operand,
//   - stalls ID on load-use hazards and on scoreboard hazards,
//   - flushes the front of the pipe on a taken branch or jump.
// A NUM_SB-entry scoreboard tracks long-latency ops (divide, uncached
// load). These ops leave ID immediately and write the regfile later,
// at WB, signalled by i_lc_valid/i_lc_tag. A saturating counter records
// every cycle in which the PC was held.
//
// Ports
//   i_clk, i_rst                   clock, synchronous active-high reset
//   i_id_rs1/2, i_id_rs1/2_used    ID-stage sources and whether they are read
//   i_id_rd, i_id_regwrite         ID-stage destination
//   i_id_long                      ID instruction is a long-latency op
//   i_ex_rs1/2                     ID/EX sources, used for forwarding
//   i_ex_memread, i_ex_rd          ID/EX load and its destination
//   i_exmem_regwrite/rd            EX/MEM writeback information
//   i_memwb_regwrite/rd            MEM/WB writeback information
//   i_redirect                     taken branch or jump resolved in EX
//   i_lc_valid, i_lc_tag           a long op writes the regfile this cycle
//   o_fwd_a/b                      10 = EX/MEM, 01 = MEM/WB, 00 = regfile
//   o_write_pc, o_write_ifid       load enables for PC and IF/ID
//   o_flush_ifid, o_flush_idex     bubble insertion
//   o_issue_tag                    entry taken by the long op leaving ID
//   o_sb_busy                      valid bit of each scoreboard entry
//   o_sb_err                       sticky: completion to an idle tag
//   o_stall_cnt                    saturating count of cycles with PC held

module hazard_scoreboard_ctrl #(
   parameter int REG_AW = 5,
   parameter int NUM_SB = 4,
   parameter int TAG_W  = 2,
   parameter int CNT_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [REG_AW-1:0] i_id_rs1,
   input  logic [REG_AW-1:0] i_id_rs2,
   input  logic              i_id_rs1_used,
   input  logic              i_id_rs2_used,
   input  logic [REG_AW-1:0] i_id_rd,
   input  logic              i_id_regwrite,
   input  logic              i_id_long,
   input  logic [REG_AW-1:0] i_ex_rs1,
   input  logic [REG_AW-1:0] i_ex_rs2,
   input  logic              i_ex_memread,
   input  logic [REG_AW-1:0] i_ex_rd,
   input  logic              i_exmem_regwrite,
   input  logic [REG_AW-1:0] i_exmem_rd,
   input  logic              i_memwb_regwrite,
   input  logic [REG_AW-1:0] i_memwb_rd,
   input  logic              i_redirect,
   input  logic              i_lc_valid,
   input  logic [TAG_W-1:0]  i_lc_tag,
   output logic [1:0]        o_fwd_a,
   output logic [1:0]        o_fwd_b,
   output logic              o_write_pc,
   output logic              o_write_ifid,
   output logic              o_flush_ifid,
   output logic              o_flush_idex,
   output logic [TAG_W-1:0]  o_issue_tag,
   output logic [NUM_SB-1:0] o_sb_busy,
   output logic              o_sb_err,
   output logic [CNT_W-1:0]  o_stall_cnt
);

   logic [NUM_SB-1:0] r_sb_valid;
   logic [REG_AW-1:0] r_sb_rd [NUM_SB];
   logic              r_sb_err;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic              w_lu;
   logic              w_raw;
   logic              w_waw;
   logic              w_full;
   logic              w_stall;
   logic              w_issue;
   logic              w_any_free;
   logic [TAG_W-1:0]  w_free_idx;
   logic              w_lc_hit;

   // Forwarding. The EX/MEM test comes last, so it overrides a MEM/WB
   // match: the younger value wins. x0 is never forwarded.
   always_comb begin
      o_fwd_a = 2'b00;
      o_fwd_b = 2'b00;
      if (i_memwb_regwrite && (i_memwb_rd != '0) && (i_memwb_rd == i_ex_rs1)) o_fwd_a = 2'b01;
      if (i_memwb_regwrite && (i_memwb_rd != '0) && (i_memwb_rd == i_ex_rs2)) o_fwd_b = 2'b01;
      if (i_exmem_regwrite && (i_exmem_rd != '0) && (i_exmem_rd == i_ex_rs1)) o_fwd_a = 2'b10;
      if (i_exmem_regwrite && (i_exmem_rd != '0) && (i_exmem_rd == i_ex_rs2)) o_fwd_b = 2'b10;
   end

   assign w_lu = i_ex_memread && (i_ex_rd != '0) &&
                 ((i_id_rs1_used && (i_ex_rd == i_id_rs1)) ||
                  (i_id_rs2_used && (i_ex_rd == i_id_rs2)));

   // Scoreboard hazards use the registered entries only. An entry that
   // is completing this cycle still blocks, so its result is read one
   // cycle after WB, once it is safely in the regfile.
   always_comb begin
      w_raw = 1'b0;
      w_waw = 1'b0;
      for (int i = 0; i < NUM_SB; i++) begin
         if (r_sb_valid[i]) begin
            if (i_id_rs1_used && (i_id_rs1 != '0) && (r_sb_rd[i] == i_id_rs1)) w_raw = 1'b1;
            if (i_id_rs2_used && (i_id_rs2 != '0) && (r_sb_rd[i] == i_id_rs2)) w_raw = 1'b1;
            if (i_id_regwrite && (i_id_rd != '0) && (r_sb_rd[i] == i_id_rd))   w_waw = 1'b1;
         end
      end
   end

   assign w_full  = i_id_long && (&r_sb_valid);
   assign w_stall = w_lu || w_raw || w_waw || w_full;

   // Find the lowest free entry. The loop runs from the top entry down,
   // so the lowest free index is the last one written.
   always_comb begin
      w_free_idx = '0;
      w_any_free = 1'b0;
      for (int i = NUM_SB - 1; i >= 0; i--) begin
         if (!r_sb_valid[i]) begin
            w_free_idx = TAG_W'(i);
            w_any_free = 1'b1;
         end
      end
   end

   // A long op that writes x0 needs no tracking, so it never allocates.
   assign w_issue = i_id_long && i_id_regwrite && (i_id_rd != '0) &&
                    !w_stall && !i_redirect && w_any_free;

   // Completion is legal only for a valid entry. A tag outside
   // 0..NUM_SB-1 never matches, so it counts as an error.
   always_comb begin
      w_lc_hit = 1'b0;
      for (int i = 0; i < NUM_SB; i++) begin
         if (i_lc_tag == TAG_W'(i)) w_lc_hit = r_sb_valid[i];
      end
   end

   // Redirect outranks stall. The wrong-path instruction in ID is
   // discarded, so any hazard it raised no longer matters.
   always_comb begin
      o_write_pc   = 1'b1;
      o_write_ifid = 1'b1;
      o_flush_ifid = 1'b0;
      o_flush_idex = 1'b0;
      if (i_redirect) begin
         o_flush_ifid = 1'b1;
         o_flush_idex = 1'b1;
      end else if (w_stall) begin
         o_write_pc   = 1'b0;
         o_write_ifid = 1'b0;
         o_flush_idex = 1'b1;
      end
   end

   assign o_issue_tag = w_free_idx;
   assign o_sb_busy   = r_sb_valid;
   assign o_sb_err    = r_sb_err;
   assign o_stall_cnt = r_stall_cnt;

   // One entry can complete while another is allocated. A completion
   // clears only a valid entry, and allocation takes only a free one,
   // so the two writes never land on the same entry.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sb_valid  <= '0;
         for (int i = 0; i < NUM_SB; i++) r_sb_rd[i] <= '0;
         r_sb_err    <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_SB; i++) begin
            if (i_lc_valid && w_lc_hit && (i_lc_tag == TAG_W'(i))) r_sb_valid[i] <= 1'b0;
            if (w_issue && (w_free_idx == TAG_W'(i))) begin
               r_sb_valid[i] <= 1'b1;
               r_sb_rd[i]    <= i_id_rd;
            end
         end
         if (i_lc_valid && !w_lc_hit) r_sb_err <= 1'b1;
         if (!o_write_pc && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

endmodule
